// File: rtl/display_pkg.sv
// Shared constants and state encoding for the multiplexed display scanner.
// The BLANK state only exists when DISPLAY_BLANK_EN is defined.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEL_W      = 3;

`ifdef DISPLAY_BLANK_EN
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDwell = 2'd1,
        StBlank = 2'd2
    } scan_state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDwell = 2'd1
    } scan_state_e;
`endif

endpackage

// File: rtl/anode_decode3to8.sv
// Digit index to active-low one-hot anode enables; all-off when not lit.
module anode_decode3to8
    import display_pkg::*;
(
    input  logic [SEL_W-1:0]      sel,
    input  logic                  lit,
    output logic [NUM_DIGITS-1:0] an
);

    always_comb begin
        an = '1;
        if (lit) begin
            an[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit display scanner with registered outputs.
// Define DISPLAY_BLANK_EN to insert an all-off anti-ghosting gap between digits.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);

    localparam int unsigned CntMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
`ifdef DISPLAY_BLANK_EN
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
`endif
    localparam logic [SEL_W-1:0] SelLast = SEL_W'(NUM_DIGITS - 1);

    scan_state_e           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  advance;
    logic                  lit_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        frame_tick_d = 1'b0;
        advance      = 1'b0;

        // Dropping en wins over any pending advance, so sel is never lost.
        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StDwell;
                    cnt_d   = '0;
                end
                StDwell: begin
                    if (cnt_q == DwellLast) begin
`ifdef DISPLAY_BLANK_EN
                        state_d = StBlank;
                        cnt_d   = '0;
`else
                        advance = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef DISPLAY_BLANK_EN
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StDwell;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        if (advance) begin
            sel_d        = sel_q + 1'b1;
            cnt_d        = '0;
            frame_tick_d = (sel_q == SelLast);
        end

        lit_d = (state_d == StDwell) && digit_mask[sel_d];
    end

    // Decode from next-state values so the registered anodes line up with sel.
    anode_decode3to8 u_anode_decode (
        .sel (sel_d),
        .lit (lit_d),
        .an  (an_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sel_q        <= '0;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl (DWELL_CYCLES=4, BLANK_CYCLES=2).
module tb_display_scan_ctrl;

    localparam int D = 4;
    localparam int B = 2;
`ifdef DISPLAY_BLANK_EN
    localparam int G = B;
`else
    localparam int G = 0;
`endif
    localparam int SLOT  = D + G;
    localparam int FRAME = 8 * SLOT;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] digit_mask;
    logic [2:0] sel;
    logic [7:0] an;
    logic       frame_tick;

    int n_vec;
    int n_err;
    int cyc;

    display_scan_ctrl #(
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic restart(input logic [7:0] mask);
        reset      = 1'b1;
        en         = 1'b0;
        digit_mask = mask;
        step();
        reset = 1'b0;
        en    = 1'b1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        en         = 1'b0;
        digit_mask = 8'hFF;
        #2;
        n_vec++;
        if (an !== 8'hFF) begin
            $display("FAIL reset_an got %h want ff", an); n_err++;
        end
        n_vec++;
        if (sel !== 3'd0) begin
            $display("FAIL reset_sel got %0d want 0", sel); n_err++;
        end
        n_vec++;
        if (frame_tick !== 1'b0) begin
            $display("FAIL reset_tick got %b want 0", frame_tick); n_err++;
        end
    endtask

    task automatic test_scan();
        int tick_cyc;
        int period;
        logic [7:0] exp_an;
        logic exp_ft;
        tick_cyc = -1;
        period   = -1;
        restart(8'hFF);
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 8; d++) begin
                for (int c = 0; c < SLOT; c++) begin
                    step();
                    exp_an = (c < D) ? ~(8'b1 << d) : 8'hFF;
                    exp_ft = (f > 0 && d == 0 && c == 0);
                    n_vec++;
                    if (an !== exp_an || sel !== 3'(d) || frame_tick !== exp_ft) begin
                        $display("FAIL scan f=%0d d=%0d c=%0d got an=%h sel=%0d tick=%b want an=%h sel=%0d tick=%b",
                                 f, d, c, an, sel, frame_tick, exp_an, d, exp_ft);
                        n_err++;
                    end
                    if (frame_tick === 1'b1) begin
                        if (tick_cyc >= 0) period = cyc - tick_cyc;
                        tick_cyc = cyc;
                    end
                end
            end
        end
        // Cover one more wrap to measure the tick period.
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (frame_tick === 1'b1) begin
                if (tick_cyc >= 0) period = cyc - tick_cyc;
                tick_cyc = cyc;
            end
        end
        n_vec++;
        if (period != FRAME) begin
            $display("FAIL frame_period got %0d want %0d", period, FRAME); n_err++;
        end
    endtask

    task automatic test_mask();
        logic [7:0] exp_an;
        restart(8'h0F);
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < SLOT; c++) begin
                step();
                exp_an = (c < D && d < 4) ? ~(8'b1 << d) : 8'hFF;
                n_vec++;
                if (an !== exp_an || sel !== 3'(d)) begin
                    $display("FAIL mask0f d=%0d c=%0d got an=%h sel=%0d want an=%h sel=%0d",
                             d, c, an, sel, exp_an, d);
                    n_err++;
                end
            end
        end
        step();
        n_vec++;
        if (frame_tick !== 1'b1 || sel !== 3'd0) begin
            $display("FAIL mask0f_wrap got tick=%b sel=%0d want tick=1 sel=0", frame_tick, sel);
            n_err++;
        end
        // Mid-slot mask change.
        restart(8'h00);
        step();
        step();
        n_vec++;
        if (an !== 8'hFF) begin
            $display("FAIL mask_dark got %h want ff", an); n_err++;
        end
        digit_mask = 8'hFF;
        step();
        n_vec++;
        if (an !== 8'hFE || sel !== 3'd0) begin
            $display("FAIL mask_change got an=%h sel=%0d want an=fe sel=0", an, sel); n_err++;
        end
        step();
        n_vec++;
        if (an !== 8'hFE || sel !== 3'd0) begin
            $display("FAIL mask_change_hold got an=%h sel=%0d want an=fe sel=0", an, sel); n_err++;
        end
        step();
        n_vec++;
        if (an !== ((G > 0) ? 8'hFF : 8'hFD) || sel !== ((G > 0) ? 3'd0 : 3'd1)) begin
            $display("FAIL mask_change_timing got an=%h sel=%0d", an, sel); n_err++;
        end
    endtask

    task automatic test_en_drop();
        restart(8'hFF);
        for (int i = 0; i < 5 * SLOT + 2; i++) step();
        n_vec++;
        if (an !== 8'hDF || sel !== 3'd5) begin
            $display("FAIL endrop_pre got an=%h sel=%0d want an=df sel=5", an, sel); n_err++;
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (an !== 8'hFF || sel !== 3'd5 || frame_tick !== 1'b0) begin
                $display("FAIL endrop_idle i=%0d got an=%h sel=%0d tick=%b want an=ff sel=5 tick=0",
                         i, an, sel, frame_tick);
                n_err++;
            end
        end
        en = 1'b1;
        for (int i = 0; i < D; i++) begin
            step();
            n_vec++;
            if (an !== 8'hDF || sel !== 3'd5) begin
                $display("FAIL endrop_resume i=%0d got an=%h sel=%0d want an=df sel=5", i, an, sel);
                n_err++;
            end
        end
        step();
        n_vec++;
        if (an !== ((G > 0) ? 8'hFF : 8'hBF) || sel !== ((G > 0) ? 3'd5 : 3'd6)) begin
            $display("FAIL endrop_slot_end got an=%h sel=%0d", an, sel); n_err++;
        end
    endtask

    task automatic test_async_reset();
        restart(8'hFF);
        for (int i = 0; i < 6 * SLOT + 2; i++) step();
        n_vec++;
        if (sel !== 3'd6 || an !== 8'hBF) begin
            $display("FAIL areset_pre got an=%h sel=%0d want an=bf sel=6", an, sel); n_err++;
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (an !== 8'hFF || sel !== 3'd0 || frame_tick !== 1'b0) begin
            $display("FAIL areset_noclk got an=%h sel=%0d tick=%b want an=ff sel=0 tick=0",
                     an, sel, frame_tick);
            n_err++;
        end
        #1 reset = 1'b0;
        for (int i = 0; i < D; i++) begin
            step();
            n_vec++;
            if (an !== 8'hFE || sel !== 3'd0) begin
                $display("FAIL areset_restart i=%0d got an=%h sel=%0d want an=fe sel=0", i, an, sel);
                n_err++;
            end
        end
    endtask

    task automatic test_wrap_drop();
        restart(8'hFF);
        for (int i = 0; i < FRAME; i++) step();
        n_vec++;
        if (sel !== 3'd7) begin
            $display("FAIL wrapdrop_pre got sel=%0d want 7", sel); n_err++;
        end
        en = 1'b0;
        step();
        n_vec++;
        if (sel !== 3'd7 || frame_tick !== 1'b0 || an !== 8'hFF) begin
            $display("FAIL wrapdrop got an=%h sel=%0d tick=%b want an=ff sel=7 tick=0",
                     an, sel, frame_tick);
            n_err++;
        end
        en = 1'b1;
        step();
        n_vec++;
        if (sel !== 3'd7 || an !== 8'h7F || frame_tick !== 1'b0) begin
            $display("FAIL wrapdrop_resume got an=%h sel=%0d tick=%b want an=7f sel=7 tick=0",
                     an, sel, frame_tick);
            n_err++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        test_reset();
        test_scan();
        test_mask();
        test_en_drop();
        test_async_reset();
        test_wrap_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
